// File: rtl/spi_cfg_slave.sv
// SPI configuration receiver: oversamples the SPI pins in the sclk domain, writes
// 16-bit {addr,data} frames into a register file and echoes the last good frame.
module spi_cfg_slave #(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned EXP_FRAMES = 32
) (
  input  logic                       sclk,
  input  logic                       rst_n,
  input  logic                       spi_clk,
  input  logic                       spi_csn,
  input  logic                       spi_sdi,
  output logic                       spi_sdo,
  input  logic [$clog2(REG_NUM)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       frame_valid,
  output logic [FRAME_BITS-1:0]      frame_word,
  output logic                       frame_err,
  output logic [5:0]                 frame_cnt,
  output logic                       cfg_done
);

  localparam int unsigned AW  = $clog2(REG_NUM);
  localparam int unsigned BCW = 5;
  localparam int unsigned DW  = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

  state_e                state_q;
  logic [2:0]            clk_sync_q, csn_sync_q, sdi_sync_q;
  logic [FRAME_BITS-1:0] shift_q, echo_q, frame_word_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic                  spi_sdo_q, frame_valid_q, frame_err_q, cfg_done_q;
  logic [5:0]            frame_cnt_q;
  logic [DW-1:0]         regfile_q [REG_NUM];
  logic [DW-1:0]         rd_data_q;

  logic                  clk_rise, clk_fall, csn_rise, csn_fall, sdi_bit;
  logic                  good_c, wr_en;
  logic [AW-1:0]         wr_addr;
  logic [5:0]            cnt_inc;

  // s1 = [0], s2 = [1], s3 = [2]; edges compare s2 against the delayed s3
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 3'b000;
      csn_sync_q <= 3'b111;
      sdi_sync_q <= 3'b000;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], spi_clk};
      csn_sync_q <= {csn_sync_q[1:0], spi_csn};
      sdi_sync_q <= {sdi_sync_q[1:0], spi_sdi};
    end
  end

  assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2];
  assign clk_fall = ~clk_sync_q[1] & clk_sync_q[2];
  assign csn_rise = csn_sync_q[1] & ~csn_sync_q[2];
  assign csn_fall = ~csn_sync_q[1] & csn_sync_q[2];
  assign sdi_bit  = sdi_sync_q[1];

  assign good_c  = (bit_cnt_q == BCW'(FRAME_BITS)) &&
                   (shift_q[FRAME_BITS-1:DW+AW] == '0);
  assign wr_en   = (state_q == CHECK) && good_c;
  assign wr_addr = shift_q[DW +: AW];
  assign cnt_inc = (frame_cnt_q == 6'h3F) ? frame_cnt_q : frame_cnt_q + 6'd1;

  // Frame FSM with registered status outputs
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      echo_q        <= '0;
      bit_cnt_q     <= '0;
      spi_sdo_q     <= 1'b0;
      frame_word_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
      cfg_done_q    <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          spi_sdo_q <= 1'b0;
          if (csn_fall) begin
            state_q <= SHIFT;
            echo_q  <= frame_word_q;
          end
        end
        SHIFT: begin
          if (csn_rise) begin
            state_q   <= CHECK;
            spi_sdo_q <= 1'b0;
          end else begin
            if (clk_rise) begin
              shift_q <= {shift_q[FRAME_BITS-2:0], sdi_bit};
              if (bit_cnt_q != BCW'(FRAME_BITS + 1)) bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
            if (clk_fall) begin
              echo_q    <= {echo_q[FRAME_BITS-2:0], 1'b0};
              spi_sdo_q <= echo_q[FRAME_BITS-1];
            end
          end
        end
        CHECK: begin
          state_q   <= IDLE;
          spi_sdo_q <= 1'b0;
          if (good_c) begin
            frame_word_q  <= shift_q;
            frame_valid_q <= 1'b1;
            frame_cnt_q   <= cnt_inc;
            if (cnt_inc == 6'(EXP_FRAMES)) cfg_done_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Register file; a same-cycle read returns the pre-write contents
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_NUM); i++) regfile_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) regfile_q[wr_addr] <= shift_q[DW-1:0];
      rd_data_q <= regfile_q[rd_addr];
    end
  end

  assign spi_sdo     = spi_sdo_q;
  assign rd_data     = rd_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_word  = frame_word_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign cfg_done    = cfg_done_q;

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Directed bench for spi_cfg_slave: drives SPI frames at 1 MHz against a 50 MHz sclk
// and compares status, echo and register-file contents with hand-computed values.
module tb_spi_cfg_slave;

  localparam int HALF = 25;

  logic        sclk = 1'b0;
  logic        rst_n, spi_clk, spi_csn, spi_sdi, spi_sdo;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_valid, frame_err, cfg_done;
  logic [15:0] frame_word;
  logic [5:0]  frame_cnt;

  int n_vec = 0;
  int n_mis = 0;
  int n_vld = 0;
  int n_ferr = 0;

  spi_cfg_slave dut (
    .sclk(sclk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_csn(spi_csn),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_valid(frame_valid), .frame_word(frame_word), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .cfg_done(cfg_done)
  );

  always #10 sclk = ~sclk;

  always @(negedge sclk) begin
    if (frame_valid) n_vld++;
    if (frame_err) n_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge sclk);
  endtask

  // Sends nb bits of w MSB first; lat = negedges after csn rise until a status pulse
  task automatic send_frame(input logic [31:0] w, input int nb,
                            output int lat, output logic [15:0] echo);
    lat  = 0;
    echo = '0;
    @(negedge sclk) spi_csn = 1'b0;
    wait_n(HALF);
    for (int i = nb - 1; i >= 0; i--) begin
      spi_sdi = w[i];
      wait_n(HALF);
      if (i != nb - 1) echo = {echo[14:0], spi_sdo};
      spi_clk = 1'b1;
      wait_n(HALF);
      spi_clk = 1'b0;
    end
    wait_n(HALF);
    if (nb > 0) echo = {echo[14:0], spi_sdo};
    spi_csn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge sclk);
      if ((frame_valid || frame_err) && lat == 0) lat = i;
    end
    wait_n(4);
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    @(negedge sclk) rd_addr = a;
    @(negedge sclk) d = rd_data;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sdo"}, 32'(spi_sdo), 32'h0);
    check({tag, "_word"}, 32'(frame_word), 32'h0);
    check({tag, "_cnt"}, 32'(frame_cnt), 32'h0);
    check({tag, "_done"}, 32'(cfg_done), 32'h0);
    check({tag, "_vld"}, 32'(frame_valid), 32'h0);
    check({tag, "_err"}, 32'(frame_err), 32'h0);
    check({tag, "_rd"}, 32'(rd_data), 32'h0);
  endtask

  initial begin
    int          lat, v0, e0;
    logic [15:0] echo;
    logic [7:0]  d;

    rst_n = 1'b0; spi_clk = 1'b0; spi_csn = 1'b1; spi_sdi = 1'b0; rd_addr = '0;
    wait_n(5);
    check_zero("reset");
    @(negedge sclk) rst_n = 1'b1;
    wait_n(5);

    // Single frame: latency, word, count and readback
    v0 = n_vld;
    send_frame(32'h0312, 16, lat, echo);
    check("single_lat", 32'(lat), 32'd4);
    check("single_pulses", 32'(n_vld - v0), 32'd1);
    check("single_word", 32'(frame_word), 32'h0312);
    check("single_cnt", 32'(frame_cnt), 32'd1);
    rd(5'd3, d);
    check("single_rd3", 32'(d), 32'h12);

    // Fresh start, then 32 frames to reach cfg_done
    @(negedge sclk) rst_n = 1'b0;
    wait_n(3);
    @(negedge sclk) rst_n = 1'b1;
    wait_n(5);
    for (int a = 0; a < 32; a++) begin
      send_frame({16'h0, 3'b000, 5'(a), 8'(a) ^ 8'hA5}, 16, lat, echo);
      if (a == 30) check("done_before_last", 32'(cfg_done), 32'h0);
    end
    check("series_cnt", 32'(frame_cnt), 32'd32);
    check("series_done", 32'(cfg_done), 32'h1);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), d);
      check($sformatf("series_rd%0d", a), 32'(d), 32'(8'(a) ^ 8'hA5));
    end

    // Echo of the previous good frame
    send_frame(32'h0155, 16, lat, echo);
    send_frame(32'h0200, 16, lat, echo);
    check("echo_bits", 32'(echo), 32'h0155);
    check("echo_word", 32'(frame_word), 32'h0200);
    check("echo_cnt", 32'(frame_cnt), 32'd34);
    check("echo_done_sticky", 32'(cfg_done), 32'h1);

    // Rejected frames: short, long, bad header, empty
    v0 = n_vld; e0 = n_ferr;
    send_frame(32'h0499, 15, lat, echo);
    check("short_lat", 32'(lat), 32'd4);
    rd(5'd4, d);
    check("short_nowrite", 32'(d), 32'hA1);
    send_frame(32'h00344, 17, lat, echo);
    check("long_lat", 32'(lat), 32'd4);
    rd(5'd3, d);
    check("long_nowrite", 32'(d), 32'hA6);
    send_frame(32'h2001, 16, lat, echo);
    rd(5'd0, d);
    check("hdr_nowrite", 32'(d), 32'hA5);
    send_frame(32'h0, 0, lat, echo);
    check("empty_lat", 32'(lat), 32'd4);
    check("err_pulses", 32'(n_ferr - e0), 32'd4);
    check("err_no_valid", 32'(n_vld - v0), 32'd0);
    check("err_cnt", 32'(frame_cnt), 32'd34);
    check("err_word", 32'(frame_word), 32'h0200);

    // Reset in the middle of frame 0x0AFF
    v0 = n_vld; e0 = n_ferr;
    @(negedge sclk) spi_csn = 1'b0;
    wait_n(HALF);
    for (int i = 15; i >= 8; i--) begin
      spi_sdi = (16'h0AFF >> i) & 16'h1;
      wait_n(HALF);
      spi_clk = 1'b1;
      wait_n(HALF);
      spi_clk = 1'b0;
    end
    wait_n(HALF / 2);
    rst_n = 1'b0;
    @(negedge sclk);
    check_zero("midrst");
    spi_csn = 1'b1;
    wait_n(3);
    @(negedge sclk) rst_n = 1'b1;
    wait_n(10);
    check("midrst_no_pulse", 32'((n_vld - v0) + (n_ferr - e0)), 32'd0);
    rd(5'd10, d);
    check("midrst_rd10", 32'(d), 32'h0);
    send_frame(32'h0A11, 16, lat, echo);
    rd(5'd10, d);
    check("after_rst_rd10", 32'(d), 32'h11);
    check("after_rst_cnt", 32'(frame_cnt), 32'd1);

    // spi_clk activity with csn high is ignored
    v0 = n_vld; e0 = n_ferr;
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk) spi_clk = 1'b1;
      wait_n(HALF);
      spi_clk = 1'b0;
      wait_n(HALF);
    end
    send_frame(32'h0107, 16, lat, echo);
    check("idle_clk_valid", 32'(n_vld - v0), 32'd1);
    check("idle_clk_err", 32'(n_ferr - e0), 32'd0);
    rd(5'd1, d);
    check("idle_clk_rd1", 32'(d), 32'h07);
    check("idle_clk_cnt", 32'(frame_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
